pulse_height_analyzer: RTL and testbench

PULSE_HEIGHT_ANALYZER -- requirements
Module: pulse_height_analyzer

---
 rtl/pulse_height_analyzer_pkg.sv | 30 +++
 rtl/pulse_height_analyzer_if.sv | 41 ++++
 rtl/pulse_height_analyzer_event_slot.sv | 83 ++++++++
 rtl/pulse_height_analyzer.sv | 149 ++++++++++++++
 tb/tb_pulse_height_analyzer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pulse_height_analyzer_pkg.sv
// ---------------------------------------------------------------------------
// v10_filter_parameters
// Shared parameters for the shaped-filter datapath and the pulse height
// analyzer built on it.
//   SIZE_FILTER_DATA : width of the signed shaped filter sample
//   TS_WIDTH         : width of the free-running timestamp counter
//   HOLDOFF_DEFAULT  : default dead time after each pulse, in clk cycles
//   HYST_DEFAULT     : default pile-up hysteresis, in filter LSBs
//   pha_state_e      : pulse height analyzer FSM states
//   sat_inc16        : 16-bit increment that sticks at 0xFFFF
// ---------------------------------------------------------------------------
package v10_filter_parameters;

  localparam int SIZE_FILTER_DATA = 16;
  localparam int TS_WIDTH         = 32;
  localparam int HOLDOFF_DEFAULT  = 8;
  localparam int HYST_DEFAULT     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2,
    ST_HOLD = 2'd3
  } pha_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pulse_height_analyzer_if.sv
// ---------------------------------------------------------------------------
// pulse_height_analyzer_if
// Event output channel of the pulse height analyzer (valid/ready handshake).
//   out_valid     : event available (master -> slave)
//   out_ready     : consumer accepts event (slave -> master)
//   out_amplitude : signed pulse maximum
//   out_timestamp : counter value at the sample holding the maximum
//   out_width     : number of samples at or above threshold
//   out_pileup    : pile-up flag
// ---------------------------------------------------------------------------
interface pulse_height_analyzer_if #(
  parameter int SIZE_FILTER_DATA = v10_filter_parameters::SIZE_FILTER_DATA,
  parameter int TS_WIDTH         = v10_filter_parameters::TS_WIDTH
) ();

  logic                               out_valid;
  logic                               out_ready;
  logic signed [SIZE_FILTER_DATA-1:0] out_amplitude;
  logic        [TS_WIDTH-1:0]         out_timestamp;
  logic        [15:0]                 out_width;
  logic                               out_pileup;

  modport master (
    output out_valid,
    output out_amplitude,
    output out_timestamp,
    output out_width,
    output out_pileup,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_amplitude,
    input  out_timestamp,
    input  out_width,
    input  out_pileup,
    output out_ready
  );

endinterface

// File: rtl/pulse_height_analyzer_event_slot.sv
// ---------------------------------------------------------------------------
// pha_event_slot
// Single-entry output register for completed pulse events with a saturating
// count of events lost while the slot was occupied.
//   clk, reset   : clock, synchronous active-low reset
//   ev_load      : a pulse completes this cycle; ev_* carry its fields
//   out_if       : valid/ready event channel (master side)
//   drop_count   : events discarded because the slot was full, sticks at 0xFFFF
// A completing event is taken whenever the slot is empty or is being drained
// on the same edge, so back-to-back accept/load keeps out_valid high.
// ---------------------------------------------------------------------------
module pha_event_slot #(
  parameter int SIZE_FILTER_DATA = v10_filter_parameters::SIZE_FILTER_DATA,
  parameter int TS_WIDTH         = v10_filter_parameters::TS_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ev_load,
  input  logic signed [SIZE_FILTER_DATA-1:0] ev_amplitude,
  input  logic        [TS_WIDTH-1:0]         ev_timestamp,
  input  logic        [15:0]                 ev_width,
  input  logic                               ev_pileup,
  pulse_height_analyzer_if.master            out_if,
  output logic        [15:0]                 drop_count
);

  import v10_filter_parameters::*;

  logic                               valid_q,  valid_d;
  logic signed [SIZE_FILTER_DATA-1:0] amp_q,    amp_d;
  logic        [TS_WIDTH-1:0]         ts_q,     ts_d;
  logic        [15:0]                 width_q,  width_d;
  logic                               pileup_q, pileup_d;
  logic        [15:0]                 drop_q,   drop_d;

  always_comb begin
    valid_d  = valid_q;
    amp_d    = amp_q;
    ts_d     = ts_q;
    width_d  = width_q;
    pileup_d = pileup_q;
    drop_d   = drop_q;
    if (ev_load) begin
      if (!valid_q || out_if.out_ready) begin
        valid_d  = 1'b1;
        amp_d    = ev_amplitude;
        ts_d     = ev_timestamp;
        width_d  = ev_width;
        pileup_d = ev_pileup;
      end else begin
        drop_d = sat_inc16(drop_q);
      end
    end else if (valid_q && out_if.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      amp_q    <= '0;
      ts_q     <= '0;
      width_q  <= '0;
      pileup_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      amp_q    <= amp_d;
      ts_q     <= ts_d;
      width_q  <= width_d;
      pileup_q <= pileup_d;
      drop_q   <= drop_d;
    end
  end

  assign out_if.out_valid     = valid_q;
  assign out_if.out_amplitude = amp_q;
  assign out_if.out_timestamp = ts_q;
  assign out_if.out_width     = width_q;
  assign out_if.out_pileup    = pileup_q;
  assign drop_count           = drop_q;

endmodule

// File: rtl/pulse_height_analyzer.sv
// ---------------------------------------------------------------------------
// pulse_height_analyzer
// Detects pulses on a shaped filter stream, measures amplitude, peak
// timestamp, width above threshold and pile-up, and presents one event per
// pulse on a valid/ready channel.
//   clk, reset   : clock, synchronous active-low reset
//   filter_data  : signed shaped sample, one per clk
//   threshold    : signed trigger level, sampled when a pulse starts
//   out_if       : event channel (master side)
//   drop_count   : events lost because the output slot was full
//   busy         : FSM is not in IDLE
// A pulse runs IDLE -> RISE -> FALL and ends on the first sample below the
// latched threshold; HOLD then blinds the detector for HOLDOFF cycles.
// ---------------------------------------------------------------------------
module pulse_height_analyzer #(
  parameter int SIZE_FILTER_DATA = v10_filter_parameters::SIZE_FILTER_DATA,
  parameter int TS_WIDTH         = v10_filter_parameters::TS_WIDTH,
  parameter int HOLDOFF          = v10_filter_parameters::HOLDOFF_DEFAULT,
  parameter int HYST             = v10_filter_parameters::HYST_DEFAULT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
  input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
  pulse_height_analyzer_if.master            out_if,
  output logic        [15:0]                 drop_count,
  output logic                               busy
);

  import v10_filter_parameters::*;

  localparam int N = SIZE_FILTER_DATA;
  // One extra bit so min + HYST never wraps at the top of the sample range.
  localparam logic signed [N:0] HYST_EXT  = $signed((N + 1)'(HYST));
  localparam logic        [15:0] HOLD_LAST = (HOLDOFF > 0) ? 16'(HOLDOFF - 1) : 16'd0;

  pha_state_e                state_q,  state_d;
  logic [TS_WIDTH-1:0]       cnt_q,    cnt_d;
  logic signed [N-1:0]       thr_q,    thr_d;
  logic signed [N-1:0]       max_q,    max_d;
  logic signed [N-1:0]       min_q,    min_d;
  logic [TS_WIDTH-1:0]       ts_q,     ts_d;
  logic [15:0]               width_q,  width_d;
  logic                      pileup_q, pileup_d;
  logic [15:0]               hold_q,   hold_d;
  logic                      ev_load;

  logic signed [N:0]         sample_ext;
  logic signed [N:0]         min_hyst;

  assign sample_ext = {filter_data[N-1], filter_data};
  assign min_hyst   = {min_q[N-1], min_q} + HYST_EXT;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    thr_d    = thr_q;
    max_d    = max_q;
    min_d    = min_q;
    ts_d     = ts_q;
    width_d  = width_q;
    pileup_d = pileup_q;
    hold_d   = hold_q;
    ev_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (filter_data >= threshold) begin
          state_d  = ST_RISE;
          thr_d    = threshold;
          max_d    = filter_data;
          ts_d     = cnt_q;
          width_d  = 16'd1;
          pileup_d = 1'b0;
        end
      end
      ST_RISE, ST_FALL: begin
        if (filter_data < thr_q) begin
          // Trackers already hold the finished event; the slot captures them now.
          ev_load = 1'b1;
          hold_d  = 16'd0;
          state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
        end else begin
          width_d = sat_inc16(width_q);
          // Strictly greater keeps the first occurrence of a tied maximum.
          if (filter_data > max_q) begin
            max_d = filter_data;
            ts_d  = cnt_q;
          end
          if (state_q == ST_RISE) begin
            if (filter_data < max_q) begin
              state_d = ST_FALL;
              min_d   = filter_data;
            end
          end else begin
            if (sample_ext > min_hyst) pileup_d = 1'b1;
            if (filter_data < min_q)   min_d    = filter_data;
          end
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = ST_IDLE;
        else                     hold_d  = hold_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      thr_q    <= '0;
      max_q    <= '0;
      min_q    <= '0;
      ts_q     <= '0;
      width_q  <= '0;
      pileup_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      thr_q    <= thr_d;
      max_q    <= max_d;
      min_q    <= min_d;
      ts_q     <= ts_d;
      width_q  <= width_d;
      pileup_q <= pileup_d;
      hold_q   <= hold_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

  pha_event_slot #(
    .SIZE_FILTER_DATA (SIZE_FILTER_DATA),
    .TS_WIDTH         (TS_WIDTH)
  ) u_slot (
    .clk          (clk),
    .reset        (reset),
    .ev_load      (ev_load),
    .ev_amplitude (max_q),
    .ev_timestamp (ts_q),
    .ev_width     (width_q),
    .ev_pileup    (pileup_q),
    .out_if       (out_if),
    .drop_count   (drop_count)
  );

endmodule

// File: tb/tb_pulse_height_analyzer.sv
// ---------------------------------------------------------------------------
// tb_pulse_height_analyzer
// Directed pulse scenarios followed by a randomized random-walk stream, all
// compared every cycle against a behavioural pulse/event model.
// ---------------------------------------------------------------------------
module tb_pulse_height_analyzer;

  localparam int N   = 16;
  localparam int TSW = 32;
  localparam int HO  = 8;
  localparam int HY  = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic signed [N-1:0] filter_data;
  logic signed [N-1:0] threshold;
  logic [15:0]         drop_count;
  logic                busy;

  pulse_height_analyzer_if #(.SIZE_FILTER_DATA(N), .TS_WIDTH(TSW)) out_if ();

  pulse_height_analyzer #(
    .SIZE_FILTER_DATA (N),
    .TS_WIDTH         (TSW),
    .HOLDOFF          (HO),
    .HYST             (HY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .filter_data (filter_data),
    .threshold   (threshold),
    .out_if      (out_if),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int n_seen;

  // Behavioural model: one pulse in flight plus a one-deep event slot.
  int m_cnt, last_ts;
  bit m_in, m_fall, m_pu;
  int m_thr, m_mx, m_mn, m_ts, m_w, m_dead;
  bit s_v, s_pu;
  int s_amp, s_ts, s_w, s_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int s, input int thr, input bit rdy, input bit rn);
    bit done;
    int e_amp, e_ts, e_w;
    bit e_pu;
    done = 0; e_amp = 0; e_ts = 0; e_w = 0; e_pu = 0;
    if (!rn) begin
      m_cnt = 0; m_in = 0; m_dead = 0;
      s_v = 0; s_drop = 0; s_amp = 0; s_ts = 0; s_w = 0; s_pu = 0;
      return;
    end
    last_ts = m_cnt;
    m_cnt   = m_cnt + 1;
    if (m_dead > 0) begin
      m_dead--;
    end else if (!m_in) begin
      if (s >= thr) begin
        m_in = 1; m_fall = 0; m_thr = thr; m_mx = s; m_ts = last_ts; m_w = 1; m_pu = 0;
      end
    end else if (s < m_thr) begin
      done = 1; e_amp = m_mx; e_ts = m_ts; e_w = m_w; e_pu = m_pu;
      m_in = 0; m_dead = HO;
    end else begin
      if (m_w < 65535) m_w++;
      if (m_fall) begin
        if (s > m_mn + HY) m_pu = 1;
        if (s < m_mn) m_mn = s;
      end else if (s < m_mx) begin
        m_fall = 1; m_mn = s;
      end
      if (s > m_mx) begin
        m_mx = s; m_ts = last_ts;
      end
    end
    if (done) begin
      if (!s_v || rdy) begin
        s_v = 1; s_amp = e_amp; s_ts = e_ts; s_w = e_w; s_pu = e_pu;
      end else if (s_drop < 65535) begin
        s_drop++;
      end
    end else if (s_v && rdy) begin
      s_v = 0;
    end
  endtask

  task automatic step(input int s);
    filter_data = N'(s);
    @(posedge clk);
    model_edge(s, int'(threshold), out_if.out_ready, reset);
    #1;
    chk("valid", out_if.out_valid, s_v);
    chk("drop",  drop_count, s_drop);
    chk("busy",  busy, (m_in || m_dead > 0));
    if (s_v) begin
      chk("amp",    out_if.out_amplitude, s_amp);
      chk("ts",     out_if.out_timestamp, s_ts);
      chk("width",  out_if.out_width, s_w);
      chk("pileup", out_if.out_pileup, s_pu);
    end
    if (out_if.out_valid && out_if.out_ready) n_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0);
  endtask

  task automatic drain();
    out_if.out_ready = 1'b1;
    step(0);
    out_if.out_ready = 1'b0;
  endtask

  initial begin
    int ts300;
    int v;
    n_tests = 0; n_fail = 0; n_seen = 0;
    reset = 1'b0; threshold = 16'sd100; filter_data = '0; out_if.out_ready = 1'b0;

    // Reset state
    step(0); step(0);
    chk("rst_amp",   out_if.out_amplitude, 32'd0);
    chk("rst_ts",    out_if.out_timestamp, 32'd0);
    chk("rst_width", out_if.out_width, 32'd0);
    chk("rst_pu",    out_if.out_pileup, 32'd0);
    reset = 1'b1;

    // Single pulse
    step(0); step(150); step(300); ts300 = last_ts; step(250);
    chk("single_pre_valid", out_if.out_valid, 32'd0);
    step(90);
    chk("single_valid", out_if.out_valid, 32'd1);
    chk("single_amp",   out_if.out_amplitude, 32'd300);
    chk("single_ts",    out_if.out_timestamp, ts300);
    chk("single_width", out_if.out_width, 32'd3);
    chk("single_pu",    out_if.out_pileup, 32'd0);
    drain(); idle(10);

    // Pile-up
    step(300); step(200); step(230); step(90);
    chk("pile_pu",  out_if.out_pileup, 32'd1);
    chk("pile_amp", out_if.out_amplitude, 32'd300);
    drain(); idle(10);

    // Back-pressure: second event dropped, first held
    step(200); step(90); idle(10); step(250); step(90); idle(2);
    chk("bp_valid", out_if.out_valid, 32'd1);
    chk("bp_amp",   out_if.out_amplitude, 32'd200);
    chk("bp_drop",  drop_count, 32'd1);

    // Simultaneous accept and load
    reset = 1'b0; step(0); reset = 1'b1;
    step(200); step(90); idle(10); step(250);
    out_if.out_ready = 1'b1; step(90); out_if.out_ready = 1'b0;
    chk("sim_valid", out_if.out_valid, 32'd1);
    chk("sim_amp",   out_if.out_amplitude, 32'd250);
    chk("sim_drop",  drop_count, 32'd0);
    drain(); idle(10);

    // Holdoff: crossing at end+4 ignored, crossing at end+9 accepted
    out_if.out_ready = 1'b1;
    n_seen = 0;
    step(200); step(90);
    idle(3); step(200); step(90); idle(3);
    step(300); step(90); idle(2);
    chk("hold_events", n_seen, 32'd2);
    chk("hold_amp",    out_if.out_amplitude, 32'd300);
    out_if.out_ready = 1'b0;
    idle(10);

    // Reset during RISE
    step(200); step(250);
    reset = 1'b0; step(0);
    chk("rstp_busy",  busy, 32'd0);
    chk("rstp_valid", out_if.out_valid, 32'd0);
    reset = 1'b1;
    step(150); step(90);
    chk("rstp_ts",   out_if.out_timestamp, 32'd0);
    chk("rstp_amp",  out_if.out_amplitude, 32'd150);
    chk("rstp_drop", drop_count, 32'd0);
    drain(); idle(10);

    // Randomized random-walk stream
    v = 0;
    for (int i = 0; i < 4000; i++) begin
      v = v + int'($urandom_range(0, 140)) - 70;
      if (v > 600)  v = 600;
      if (v < -300) v = -300;
      if ($urandom_range(0, 19) == 0) threshold = N'(int'($urandom_range(0, 250)) - 50);
      out_if.out_ready = ($urandom_range(0, 9) < 6);
      reset = ($urandom_range(0, 399) != 0);
      step(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
